// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// 8N1 UART transmitter fed by a byte FIFO, with a baud divider sampled
// at runtime.
// A valid/ready byte stream fills the FIFO. The frame FSM takes one byte
// per frame and shifts it out LSB first:
//   one start bit (0), eight data bits, one stop bit (1).
// Each symbol lasts eff_div clock cycles, where eff_div = max(div_i, 2).
// eff_div is latched when a byte is popped, so the frame in flight keeps its
// timing if div_i changes.
//
// Ports
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   div_i    : clock cycles per UART symbol (0 and 1 act as 2)
//   data_i   : byte to enqueue
//   valid_i  : data_i valid
//   ready_o  : FIFO can accept a byte (not full)
//   level_o  : bytes waiting in the FIFO (the byte being shifted is not counted)
//   idle_o   : FIFO empty and FSM idle
//   tx_o     : registered serial line, idle high
//
// FSM states
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (line low) for eff_div cycles
//   DATA  | data bit bit_idx_q on the line, LSB first
//   STOP  | stop bit (line high); pops the next byte at its end if one is queued

module uart_tx_fifo #(
    parameter int unsigned Depth    = 8,
    parameter int unsigned DivWidth = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [DivWidth-1:0]        div_i,
    input  logic [7:0]                 data_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [$clog2(Depth):0]     level_o,
    output logic                       idle_o,
    output logic                       tx_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = PtrW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    // The pointers carry one extra wrap bit, so the difference between them
    // gives the fill level directly, including the full case.
    logic [7:0]      mem_q [Depth];
    logic [PtrW:0]   wr_ptr_q;
    logic [PtrW:0]   rd_ptr_q;
    logic [LvlW-1:0] level;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            pop;
    logic [7:0]      head_byte;

    assign level      = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LvlW'(Depth));
    assign head_byte  = mem_q[rd_ptr_q[PtrW-1:0]];

    // ready_o comes only from full. A pop in the same cycle does not free
    // space until the next cycle, so there is no pass-through path.
    assign push = valid_i && !fifo_full;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t              state_q;
    logic [DivWidth-1:0] eff_div_q;
    logic [DivWidth-1:0] cyc_cnt_q;
    logic [2:0]          bit_idx_q;
    logic [7:0]          shift_q;
    logic                tx_q;
    logic                sym_end;
    logic [DivWidth-1:0] div_clamped;
    logic [2:0]          bit_idx_nxt;

    assign div_clamped = (div_i < DivWidth'(2)) ? DivWidth'(2) : div_i;
    assign sym_end     = (cyc_cnt_q == eff_div_q - DivWidth'(1));
    assign bit_idx_nxt = bit_idx_q + 3'd1;

    // A pop happens only when a frame starts: from IDLE, or straight out of
    // STOP so that the next start bit follows the stop bit with no gap.
    assign pop = !fifo_empty &&
                 ((state_q == IDLE) || ((state_q == STOP) && sym_end));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            eff_div_q <= DivWidth'(2);
            cyc_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q   <= head_byte;
                        eff_div_q <= div_clamped;
                        cyc_cnt_q <= '0;
                        tx_q      <= 1'b0;
                        state_q   <= START;
                    end
                end

                START: begin
                    if (sym_end) begin
                        cyc_cnt_q <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= DATA;
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    if (sym_end) begin
                        cyc_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_nxt;
                            tx_q      <= shift_q[bit_idx_nxt];
                        end
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + 1'b1;
                    end
                end

                STOP: begin
                    if (sym_end) begin
                        cyc_cnt_q <= '0;
                        if (!fifo_empty) begin
                            shift_q   <= head_byte;
                            eff_div_q <= div_clamped;
                            tx_q      <= 1'b0;
                            state_q   <= START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + 1'b1;
                    end
                end

                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ready_o = !fifo_full;
    assign level_o = level;
    assign idle_o  = fifo_empty && (state_q == IDLE);
    assign tx_o    = tx_q;

endmodule
